// File: rtl/key_seq_tracker.sv
// key_seq_tracker
//   Watches qualified bus reads for a fixed sequence of address nibbles
//   (the key). When the whole key has been seen in order, the block unlocks.
//   While unlocked, each qualified read shifts out one bit of a 6-bit LFSR,
//   XORed with BA4, on sdrd.
//
// Optional feature (macro KEYSEQ_RELOCK_EN):
//   When the macro is defined, a qualified read of nibble 4'hF while unlocked
//   relocks the block. Without the macro, only reset leaves UNLOCKED.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   sser     in   active-low select
//   br_w     in   bus read/write, 1 = read
//   ba[9:0]  in   bus address bits 13..4 (ba[9]=BA13, ba[8]=BA12, ba[3:0]=BA7..BA4)
//   sdrd     out  serial data bit (0 unless sdrd_oe)
//   sdrd_oe  out  drive enable for sdrd
//   unlocked out  registered, key accepted
//   step     out  number of key nibbles matched so far
//
// state    | meaning
// ---------+------------------------------------------------------------
// LOCKED   | matching key nibbles; step = nibbles matched, idle timeout
// UNLOCKED | key accepted; qualified reads advance the LFSR onto sdrd

module key_seq_tracker #(
  parameter int unsigned          SEQ_LEN   = 8,
  parameter logic [4*SEQ_LEN-1:0] KEY       = 32'h3A5C_96E1,
  parameter int unsigned          TIMEOUT   = 255,
  parameter logic [5:0]           LFSR_SEED = 6'h2B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sser,
  input  logic [9:0] ba,
  input  logic       br_w,
  output logic       sdrd,
  output logic       sdrd_oe,
  output logic       unlocked,
  output logic [3:0] step
);

  typedef enum logic {
    LOCKED   = 1'b0,
    UNLOCKED = 1'b1
  } state_t;

  // Key zero-extended to the 16-nibble maximum so the nibble select below is
  // always in range with a fixed-width index.
  localparam logic [63:0] KEY_EXT   = 64'(KEY);
  localparam logic [3:0]  LAST_STEP = 4'(SEQ_LEN - 1);
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] idle_q, idle_d;
  logic [5:0]  lfsr_q, lfsr_d;
  logic        unlocked_q, unlocked_d;

  logic       qual;
  logic [3:0] ba_nib;
  logic [3:0] key_nib;
  logic       unused_ba;

  assign qual      = ~sser & ~ba[9] & ba[8] & br_w;
  assign ba_nib    = ba[3:0];
  assign key_nib   = KEY_EXT[{step_q, 2'b00} +: 4];
  assign unused_ba = ^ba[7:4];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idle_d  = idle_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      LOCKED: begin
        if (qual) begin
          idle_d = '0;
          if (ba_nib == key_nib) begin
            if (step_q == LAST_STEP) begin
              state_d = UNLOCKED;
              step_d  = '0;
              lfsr_d  = LFSR_SEED;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else begin
            // A mismatching nibble may itself be the start of a new attempt.
            step_d = (ba_nib == KEY_EXT[3:0]) ? 4'd1 : 4'd0;
          end
        end else if (step_q != 4'd0) begin
          if (idle_q == IDLE_LAST) begin
            step_d = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 16'd1;
          end
        end
      end
      UNLOCKED: begin
        idle_d = '0;
        if (qual) begin
          // x^6 + x^5 + 1, shifting toward bit 0.
          lfsr_d = {lfsr_q[0] ^ lfsr_q[1], lfsr_q[5:1]};
`ifdef KEYSEQ_RELOCK_EN
          if (ba_nib == 4'hF) begin
            state_d = LOCKED;
            step_d  = '0;
          end
`endif
        end
      end
      default: begin
        state_d = LOCKED;
        step_d  = '0;
        idle_d  = '0;
      end
    endcase
    unlocked_d = (state_d == UNLOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOCKED;
      step_q     <= '0;
      idle_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      idle_q     <= idle_d;
      lfsr_q     <= lfsr_d;
      unlocked_q <= unlocked_d;
    end
  end

  assign unlocked = unlocked_q;
  assign step     = step_q;
  assign sdrd_oe  = qual & unlocked_q;
  assign sdrd     = sdrd_oe & (lfsr_q[0] ^ ba[0]);

endmodule

// File: tb/tb_key_seq_tracker.sv
module tb_key_seq_tracker;

  logic       clk;
  logic       rst;
  logic       sser;
  logic [9:0] ba;
  logic       br_w;
  logic       sdrd;
  logic       sdrd_oe;
  logic       unlocked;
  logic [3:0] step;

  int n_checks;
  int n_fail;

  logic [3:0] key_nibs [8];
  logic       lfsr_bits [7];

  key_seq_tracker dut (
    .clk      (clk),
    .rst      (rst),
    .sser     (sser),
    .ba       (ba),
    .br_w     (br_w),
    .sdrd     (sdrd),
    .sdrd_oe  (sdrd_oe),
    .unlocked (unlocked),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    sser = 1'b1;
    br_w = 1'b1;
    ba   = 10'b01_0000_0000;
  endtask

  // One qualified read sampled by a single rising edge; outputs settle #1 later.
  task automatic qread(input logic [3:0] nib);
    @(negedge clk);
    sser = 1'b0;
    br_w = 1'b1;
    ba   = {2'b01, 4'b0000, nib};
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  // In-window write: must not be treated as a key access but is still idle time.
  task automatic qwrite(input logic [3:0] nib);
    @(negedge clk);
    sser = 1'b0;
    br_w = 1'b0;
    ba   = {2'b01, 4'b0000, nib};
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic idle_clocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic unlock_seq();
    for (int i = 0; i < 8; i++) qread(key_nibs[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #12;
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step: got %0d want 0", step); end
    n_checks++;
    if (unlocked !== 1'b0) begin n_fail++; $display("FAIL reset_unlocked: got %b want 0", unlocked); end
    n_checks++;
    if ({sdrd_oe, sdrd} !== 2'b00) begin n_fail++; $display("FAIL reset_sd: got %b want 00", {sdrd_oe, sdrd}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_key();
    for (int i = 0; i < 7; i++) begin
      qread(key_nibs[i]);
      n_checks++;
      if (step !== 4'(i + 1)) begin n_fail++; $display("FAIL full_key_step%0d: got %0d want %0d", i, step, i + 1); end
      n_checks++;
      if (unlocked !== 1'b0) begin n_fail++; $display("FAIL full_key_early%0d: got %b want 0", i, unlocked); end
    end
    qread(key_nibs[7]);
    n_checks++;
    if (unlocked !== 1'b1) begin n_fail++; $display("FAIL full_key_unlocked: got %b want 1", unlocked); end
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL full_key_step_clear: got %0d want 0", step); end
    do_reset();
  endtask

  task automatic test_mismatch();
    logic [3:0] nibs [5];
    logic [3:0] exp  [5];
    nibs = '{4'h1, 4'hE, 4'h1, 4'hE, 4'h6};
    exp  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 5; i++) begin
      qread(nibs[i]);
      n_checks++;
      if (step !== exp[i]) begin n_fail++; $display("FAIL mismatch_step%0d: got %0d want %0d", i, step, exp[i]); end
    end
    // Mismatch with a non-start nibble drops to 0.
    qread(4'h7);
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL mismatch_zero: got %0d want 0", step); end
    // Write cycles and out-of-window reads don't advance the match.
    qread(4'h1);
    qwrite(4'hE);
    @(negedge clk);
    sser = 1'b0; br_w = 1'b1; ba = {2'b11, 4'b0000, 4'hE};
    @(posedge clk);
    #1;
    drive_idle();
    n_checks++;
    if (step !== 4'd1) begin n_fail++; $display("FAIL ignore_write_oow: got %0d want 1", step); end
    do_reset();
  endtask

  task automatic test_timeout();
    qread(4'h1);
    qread(4'hE);
    qread(4'h6);
    // 4 of the idle clocks are writes, which still count as idle.
    qwrite(4'h9);
    qwrite(4'h9);
    qwrite(4'h9);
    qwrite(4'h9);
    idle_clocks(250);
    n_checks++;
    if (step !== 4'd3) begin n_fail++; $display("FAIL timeout_254: got %0d want 3", step); end
    idle_clocks(1);
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL timeout_255: got %0d want 0", step); end
    do_reset();
  endtask

  task automatic test_lfsr();
    unlock_seq();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sser = 1'b0; br_w = 1'b1;
      ba = {2'b01, 4'b0000, 3'b000, (i == 6) ? 1'b1 : 1'b0};
      #1;
      n_checks++;
      if (sdrd_oe !== 1'b1) begin n_fail++; $display("FAIL lfsr_oe%0d: got %b want 1", i, sdrd_oe); end
      n_checks++;
      if (sdrd !== (lfsr_bits[i] ^ (i == 6))) begin
        n_fail++; $display("FAIL lfsr_bit%0d: got %b want %b", i, sdrd, lfsr_bits[i] ^ (i == 6));
      end
      @(posedge clk);
      #1;
      drive_idle();
      #1;
      n_checks++;
      if ({sdrd_oe, sdrd} !== 2'b00) begin n_fail++; $display("FAIL lfsr_idle%0d: got %b want 00", i, {sdrd_oe, sdrd}); end
    end
    do_reset();
    // Locked: a qualified read never enables the output.
    @(negedge clk);
    sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'b0000, 4'h1};
    #1;
    n_checks++;
    if (sdrd_oe !== 1'b0) begin n_fail++; $display("FAIL locked_oe: got %b want 0", sdrd_oe); end
    drive_idle();
    do_reset();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) qread(key_nibs[i]);
    n_checks++;
    if (step !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 5", step); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL rstmid_async: got %0d want 0", step); end
    @(negedge clk);
    rst = 1'b0;
    qread(key_nibs[5]);
    n_checks++;
    if (step !== 4'd0) begin n_fail++; $display("FAIL rstmid_resume: got %0d want 0", step); end

    unlock_seq();
    @(negedge clk);
    sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'b0000, 4'h0};
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({unlocked, sdrd_oe, sdrd, step} !== 7'd0) begin
      n_fail++; $display("FAIL rstunl_async: got %b want 0", {unlocked, sdrd_oe, sdrd, step});
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    qread(4'h1);
    n_checks++;
    if ({unlocked, step} !== 5'b0_0001) begin n_fail++; $display("FAIL rstunl_relearn: got %b want 00001", {unlocked, step}); end
    for (int i = 1; i < 8; i++) qread(key_nibs[i]);
    n_checks++;
    if (unlocked !== 1'b1) begin n_fail++; $display("FAIL rstunl_reunlock: got %b want 1", unlocked); end
    do_reset();
  endtask

  task automatic test_relock();
    unlock_seq();
    @(negedge clk);
    sser = 1'b0; br_w = 1'b1; ba = {2'b01, 4'b0000, 4'hF};
    #1;
    n_checks++;
    if (sdrd_oe !== 1'b1) begin n_fail++; $display("FAIL relock_oe: got %b want 1", sdrd_oe); end
    @(posedge clk);
    #1;
    drive_idle();
`ifdef KEYSEQ_RELOCK_EN
    n_checks++;
    if (unlocked !== 1'b0) begin n_fail++; $display("FAIL relock_unlocked: got %b want 0", unlocked); end
    qread(4'h1);
    n_checks++;
    if (step !== 4'd1) begin n_fail++; $display("FAIL relock_step: got %0d want 1", step); end
`else
    n_checks++;
    if (unlocked !== 1'b1) begin n_fail++; $display("FAIL relock_unlocked: got %b want 1", unlocked); end
    qread(4'h1);
    n_checks++;
    if ({unlocked, step} !== 5'b1_0000) begin n_fail++; $display("FAIL relock_step: got %b want 10000", {unlocked, step}); end
`endif
    do_reset();
  endtask

  initial begin
    key_nibs  = '{4'h1, 4'hE, 4'h6, 4'h9, 4'hC, 4'h5, 4'hA, 4'h3};
    // Seed 6'h2B stepped by x^6+x^5+1 toward bit 0: 2B,15,2A,35,3A,3D,3E -> bit 0
    lfsr_bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    n_checks  = 0;
    n_fail    = 0;
    test_reset();
    test_full_key();
    test_mismatch();
    test_timeout();
    test_lfsr();
    test_reset_mid();
    test_relock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
